digit_serial_subtractor: RTL
============================

# digit_serial_subtractor

Multi-cycle N-bit subtractor that computes a − b − bin by processing SIZE bits per clock, LSB digit first. It is the subtraction companion to the team's adder library. It trades latency for area: one SIZE-bit subtract slice is reused over N/SIZE cycles, instead of the full-width carry-select logic. A start/busy/done handshake lets a controller or bench launch one operation at a time and collect a held result.

## Interface
Parameters:
- N, 32, operand width in bits; must be a multiple of SIZE.
- SIZE, 4, digit width in bits processed per cycle; 1 ≤ SIZE ≤ N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only while busy=0.
- a  input  N  minuend; captured on the accepting edge.
- b  input  N  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress (state RUN).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- diff  output  N  a − b − bin, modulo 2^N.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed overflow: (a[N-1] ≠ b[N-1]) and (diff[N-1] ≠ a[N-1]).

## Operation
- K = N/SIZE digit steps per operation.
- States:
  - IDLE
  - RUN: a step counter runs 0..K−1.
  - DONE: lasts exactly one cycle.
- IDLE: if start=1, latch a, b and bin into working registers, clear the counter, and go to RUN. Otherwise stay.
- RUN, each cycle:
  - Take the low SIZE bits of the working a and b, plus the running borrow.
  - Compute d = a_dig − b_dig − borrow as a (SIZE+1)-bit result.
  - The new borrow is the MSB of that result.
  - Shift the working a and b right by SIZE.
  - Shift d into the top of the working difference register.
  - Increment the counter.
- At the last step (counter = K−1), go to DONE. On that same edge, load diff, bout and ovf from the completed working values. ovf uses the latched operand sign bits.
- DONE: done=1 for this cycle only.
  - If start=1, accept new operands (as in IDLE) and go to RUN.
  - Otherwise go to IDLE.
- Outputs:
  - diff, bout and ovf change only on entry to DONE.
  - Between operations they hold their last values.
- start while busy=1 is ignored; operands are not re-latched.
- a, b and bin may change freely after the accepting edge.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, working registers 0; busy=0, done=0, diff=0, bout=0, ovf=0.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced and outputs return to 0.
- Let edge E0 be the edge that accepts start:
  - busy=1 from E0 through the edge that enters DONE.
  - Digit steps occur on edges E1..EK.
  - Edge EK enters DONE, with busy=0 and done=1.
  - Result latency is K cycles after the accepting edge; done is visible in cycle K. For N=32 and SIZE=4, that is 8 cycles.
- Back-to-back: start held high in the DONE cycle restarts with no idle gap. Throughput is one result per K cycles.
- busy and done are never high together.
- SIZE = N degenerates to K=1: one RUN cycle, then DONE.

## Test plan
- Simple subtraction: a=0x0000000A, b=0x00000003, bin=0 → diff=0x00000007, bout=0, ovf=0. done pulses exactly 8 cycles after the accepting edge and is high for 1 cycle.
- Wrap-around: a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0.
- Signed overflow and borrow-in:
  - a=0x80000000, b=0x00000001, bin=0 → diff=0x7FFFFFFF, bout=0, ovf=1.
  - a=b=0xAAAAAAAA, bin=1 → diff=0xFFFFFFFF, bout=1, ovf=0.
- Handshake:
  - Pulse start with a=0x12345678, b=0x00000078.
  - Three cycles later, pulse start with different operands while busy=1.
  - Required: the second start is ignored and the result is diff=0x12345600.
  - Hold start high during DONE with a=0xA5A5A5A5, b=0x5A5A5A5A: a new RUN begins immediately and yields diff=0x4B4B4B4B, bout=0.
- Reset mid-operation:
  - Assert rst during step 4 of an operation: busy, done, diff, bout and ovf go to 0 immediately, and no done pulse follows.
  - After release, a fresh operation gives correct results.
- Random self-check: at least 1000 random a, b, bin values, compared against the golden model {bout, diff} = {1'b0,a} − {1'b0,b} − bin, including ovf. Run at N=32/SIZE=4 and at N=16/SIZE=16.

Source files
------------

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//   Computes diff = a - b - bin (mod 2^N) over K = N/SIZE cycles, one
//   SIZE-bit digit per cycle, LSB digit first. One operation at a time
//   via a start/busy/done handshake; results hold between operations.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : launch request, sampled only while busy=0
//   a, b  : N-bit minuend / subtrahend, captured on the accepting edge
//   bin   : borrow-in, captured on the accepting edge
//   busy  : high while digit steps are running
//   done  : one-cycle pulse when diff/bout/ovf are updated
//   diff  : a - b - bin modulo 2^N
//   bout  : borrow-out (unsigned a < b + bin)
//   ovf   : signed overflow of the subtraction
module digit_serial_subtractor #(
    parameter int N    = 32,
    parameter int SIZE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int K  = N / SIZE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if ((SIZE < 1) || (SIZE > N) || ((N % SIZE) != 0)) begin : g_bad_params
        $error("digit_serial_subtractor: N must be a positive multiple of SIZE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    wa_q, wa_d;
    logic [N-1:0]    wb_q, wb_d;
    logic [N-1:0]    wd_q, wd_d;
    logic            borrow_q, borrow_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // One digit slice: (SIZE+1)-bit result, MSB is the outgoing borrow.
    logic [SIZE:0]   dig;
    logic [N-1:0]    dig_ext;
    logic [N-1:0]    wd_step;
    logic            last_step;

    always_comb begin
        dig       = {1'b0, wa_q[SIZE-1:0]} - {1'b0, wb_q[SIZE-1:0]}
                  - {{SIZE{1'b0}}, borrow_q};
        dig_ext   = N'(dig[SIZE-1:0]);
        // New digit enters at the top; after K steps the first digit
        // has been pushed down to bit 0.
        wd_step   = (wd_q >> SIZE) | (dig_ext << (N - SIZE));
        last_step = (cnt_q == CW'(K - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        wb_d     = wb_q;
        wd_d     = wd_q;
        borrow_d = borrow_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            RUN: begin
                wa_d     = wa_q >> SIZE;
                wb_d     = wb_q >> SIZE;
                wd_d     = wd_step;
                borrow_d = dig[SIZE];
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    diff_d  = wd_step;
                    bout_d  = dig[SIZE];
                    ovf_d   = (sa_q != sb_q) && (wd_step[N-1] != sa_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation; DONE
                // otherwise falls back to IDLE after its single cycle.
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    wa_d     = a;
                    wb_d     = b;
                    wd_d     = '0;
                    borrow_d = bin;
                    sa_d     = a[N-1];
                    sb_d     = b[N-1];
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
            wd_q     <= '0;
            borrow_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            wd_q     <= wd_d;
            borrow_q <= borrow_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
